// File: rtl/ifetch_pkg.sv
// Shared widths, FSM encoding and helpers for the instruction-fetch front end.
package ifetch_pkg;

  localparam int unsigned ASIZE_DEF = 16;
  localparam int unsigned ISIZE_DEF = 32;

  localparam logic STATE_FETCH_ENC   = 1'b0;
  localparam logic STATE_DISCARD_ENC = 1'b1;

  typedef enum logic {
    ST_FETCH   = STATE_FETCH_ENC,
    ST_DISCARD = STATE_DISCARD_ENC
  } fetch_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry FIFO of {pc, instr} between the memory response and decode.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter int unsigned ASIZE = ASIZE_DEF,
  parameter int unsigned ISIZE = ISIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [ASIZE-1:0] push_pc_i,
  input  logic [ISIZE-1:0] push_instr_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [1:0]       count_o,
  output logic [ASIZE-1:0] head_pc_o,
  output logic [ISIZE-1:0] head_instr_o
);

  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && !flush_i && ((count_q != 2'd2) || do_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [ASIZE-1:0] pc_q;
    logic [ISIZE-1:0] instr_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pc_q    <= '0;
        instr_q <= '0;
      end else if (do_push && (wr_ptr_q == 1'(gi))) begin
        pc_q    <= push_pc_i;
        instr_q <= push_instr_i;
      end
    end
  end

  // Flush only rewinds the pointers; stale entry contents are hidden by count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign count_o      = count_q;
  assign head_pc_o    = rd_ptr_q ? g_entry[1].pc_q    : g_entry[0].pc_q;
  assign head_instr_o = rd_ptr_q ? g_entry[1].instr_q : g_entry[0].instr_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC sequencing, single-outstanding imem handshake, redirect flush.
// Define IFETCH_PERF_EN to add saturating fetch/stall/flush counters.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned      ASIZE    = ASIZE_DEF,
  parameter int unsigned      ISIZE    = ISIZE_DEF,
  parameter logic [ASIZE-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [ASIZE-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [ISIZE-1:0] imem_rdata,
  output logic             id_valid,
  output logic [ISIZE-1:0] id_instr,
  output logic [ASIZE-1:0] id_pc,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [ASIZE-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt
`endif
);

  fetch_state_e     state_q, state_d;
  logic [ASIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic             req_q, req_d;
  logic [1:0]       buf_count;
  logic [1:0]       count_post;
  logic             complete, pending_left, pop, push, flush;

  assign complete     = req_q && imem_rvalid;
  assign pending_left = req_q && !imem_rvalid;
  assign pop          = id_valid && id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    count_post = buf_count - {1'b0, pop};

    if (redirect_valid) begin
      flush      = 1'b1;
      count_post = 2'd0;
      fetch_pc_d = redirect_pc;
      state_d    = pending_left ? ST_DISCARD : ST_FETCH;
    end else if (state_q == ST_DISCARD) begin
      if (complete) state_d = ST_FETCH;
    end else if (complete) begin
      push       = 1'b1;
      count_post = count_post + 2'd1;
      fetch_pc_d = addr_q + ASIZE'(1);
    end

    // An unfinished request always wins; a new one issues only with buffer room.
    if (pending_left) begin
      req_d = 1'b1;
    end else if ((state_d == ST_FETCH) && (count_post < 2'd2)) begin
      req_d  = 1'b1;
      addr_d = fetch_pc_d;
    end
  end

  ifetch_buf #(
    .ASIZE(ASIZE),
    .ISIZE(ISIZE)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_pc_i   (addr_q),
    .push_instr_i(imem_rdata),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (buf_count),
    .head_pc_o   (id_pc),
    .head_instr_o(id_instr)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = (buf_count != 2'd0);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push)                  perf_fetch_q <= sat_inc32(perf_fetch_q);
      if (id_valid && !id_ready) perf_stall_q <= sat_inc32(perf_stall_q);
      if (redirect_valid)        perf_flush_q <= sat_inc32(perf_flush_q);
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: vector table, directed redirect sequences, random stream model.
module tb_ifetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic        w_req;
  logic [15:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [15:0] w_pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] pf_fetch, pf_stall, pf_flush;
  logic [31:0] wf_fetch, wf_stall, wf_flush;
`endif

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A3C, a * 16'd7 + 16'd1};
  endfunction

  assign imem_rdata = mem_word(imem_addr);
  assign w_rdata    = mem_word(w_addr);

  ifetch_unit #(.ASIZE(16), .ISIZE(32), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(pf_fetch), .perf_stall_cnt(pf_stall), .perf_flush_cnt(pf_flush)
`endif
  );

  ifetch_unit #(.ASIZE(16), .ISIZE(32), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(1'b1), .imem_rdata(w_rdata),
    .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc), .id_ready(1'b1),
    .redirect_valid(1'b0), .redirect_pc(16'h0000)
`ifdef IFETCH_PERF_EN
    , .perf_fetch_cnt(wf_fetch), .perf_stall_cnt(wf_stall), .perf_flush_cnt(wf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic        rvalid;
    logic        exp_req;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [20];

  task automatic setv(input int i, input logic r, input logic v, input logic q,
                      input logic [15:0] a, input logic val, input logic [15:0] pc);
    vecs[i].ready     = r;
    vecs[i].rvalid    = v;
    vecs[i].exp_req   = q;
    vecs[i].exp_addr  = a;
    vecs[i].exp_valid = val;
    vecs[i].exp_pc    = pc;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare the fetch/decode outputs; address only matters while a request is up.
  task automatic expect_out(input string tag, input logic q, input logic [15:0] a,
                            input logic val, input logic [15:0] pc);
    $display("[%s] req=%0b addr=%04h valid=%0b pc=%04h instr=%08h",
             tag, imem_req, imem_addr, id_valid, id_pc, id_instr);
    chk({tag, ".req"}, imem_req, q);
    if (q) chk({tag, ".addr"}, imem_addr, a);
    chk({tag, ".valid"}, id_valid, val);
    if (val) begin
      chk({tag, ".pc"}, id_pc, pc);
      chk({tag, ".instr"}, id_instr, mem_word(pc));
    end
  endtask

  logic [15:0] exp_pc;
  logic        prev_hold, prev_redir, prev_free;
  logic [15:0] prev_addr, prev_target;
  int          pops;

  initial begin
    rst = 1'b1;
    imem_rvalid = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;

    setv(0, 1, 1, 0, 16'd0, 0, 16'd0);
    setv(1, 1, 1, 1, 16'd0, 0, 16'd0);
    setv(2, 1, 1, 1, 16'd1, 1, 16'd0);
    setv(3, 1, 1, 1, 16'd2, 1, 16'd1);
    setv(4, 1, 1, 1, 16'd3, 1, 16'd2);
    setv(5, 1, 1, 1, 16'd4, 1, 16'd3);
    setv(6, 0, 1, 1, 16'd5, 1, 16'd4);
    for (int i = 7; i <= 10; i++) setv(i, 0, 1, 0, 16'd0, 1, 16'd4);
    setv(11, 1, 1, 0, 16'd0, 1, 16'd4);
    setv(12, 1, 1, 1, 16'd6, 1, 16'd5);
    setv(13, 1, 1, 1, 16'd7, 1, 16'd6);
    setv(14, 1, 0, 1, 16'd8, 1, 16'd7);
    setv(15, 1, 0, 1, 16'd8, 0, 16'd0);
    setv(16, 1, 0, 1, 16'd8, 0, 16'd0);
    setv(17, 1, 1, 1, 16'd8, 0, 16'd0);
    setv(18, 1, 1, 1, 16'd9, 1, 16'd8);
    setv(19, 1, 1, 1, 16'd10, 1, 16'd9);

    repeat (3) @(negedge clk);
    $display("[reset] req=%0b addr=%04h valid=%0b", imem_req, imem_addr, id_valid);
    chk("reset.req", imem_req, 1'b0);
    chk("reset.addr", imem_addr, 16'h0000);
    chk("reset.valid", id_valid, 1'b0);
    chk("reset.instr", id_instr, 32'h0);
    chk("reset.pc", id_pc, 16'h0000);
    chk("reset.wrap_addr", w_addr, 16'hFFFF);
`ifdef IFETCH_PERF_EN
    chk("reset.perf_fetch", pf_fetch, 32'd0);
    chk("reset.perf_stall", pf_stall, 32'd0);
    chk("reset.perf_flush", pf_flush, 32'd0);
`endif
    rst = 1'b0;

    for (int k = 0; k < 20; k++) begin
      expect_out($sformatf("vec%0d", k), vecs[k].exp_req, vecs[k].exp_addr,
                 vecs[k].exp_valid, vecs[k].exp_pc);
      if (k == 1) begin
        chk("wrap.req1", w_req, 1'b1);
        chk("wrap.addr1", w_addr, 16'hFFFF);
      end
      if (k == 2) begin
        chk("wrap.addr2", w_addr, 16'h0000);
        chk("wrap.valid2", w_valid, 1'b1);
        chk("wrap.pc2", w_pc, 16'hFFFF);
      end
      id_ready = vecs[k].ready;
      imem_rvalid = vecs[k].rvalid;
      @(negedge clk);
    end

    // Redirect while the request to 11 is still pending -> discard its response.
    expect_out("disc0", 1, 16'd11, 1, 16'd10);
    redirect_valid = 1'b1; redirect_pc = 16'h0100; imem_rvalid = 1'b0; id_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_out("disc1", 1, 16'd11, 0, 16'd0);
    @(negedge clk);
    expect_out("disc2", 1, 16'd11, 0, 16'd0);
    imem_rvalid = 1'b1;
    @(negedge clk);
    expect_out("disc3", 1, 16'h0100, 0, 16'd0);
    @(negedge clk);
    expect_out("disc4", 1, 16'h0101, 1, 16'h0100);

    // Redirect coincident with completion -> that response dropped, target issued next.
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    expect_out("coin1", 1, 16'h0040, 0, 16'd0);
    @(negedge clk);
    expect_out("coin2", 1, 16'h0041, 1, 16'h0040);

    // Reset in the middle of a transfer takes effect immediately.
    rst = 1'b1;
    #1;
    $display("[midreset] req=%0b valid=%0b", imem_req, id_valid);
    chk("midreset.req", imem_req, 1'b0);
    chk("midreset.valid", id_valid, 1'b0);
    imem_rvalid = 1'b0; id_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random traffic against a stream-level model of the delivered instructions.
    exp_pc = 16'h0000;
    prev_hold = 1'b0; prev_redir = 1'b0; prev_free = 1'b0;
    prev_addr = '0; prev_target = '0;
    pops = 0;
    for (int n = 0; n < 2000; n++) begin
      if (prev_hold) begin
        chk("rnd.hold_req", imem_req, 1'b1);
        chk("rnd.hold_addr", imem_addr, prev_addr);
      end
      if (prev_redir) begin
        chk("rnd.redir_flush", id_valid, 1'b0);
        if (prev_free) begin
          chk("rnd.redir_req", imem_req, 1'b1);
          chk("rnd.redir_addr", imem_addr, prev_target);
        end
      end
      id_ready = ($urandom % 4) != 0;
      imem_rvalid = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 20) == 0;
      redirect_pc = (($urandom % 2) == 0) ? 16'($urandom) : 16'hFFFE;
      if (id_valid && id_ready) begin
        $display("[rnd%0d] pop pc=%04h instr=%08h", n, id_pc, id_instr);
        chk("rnd.pc", id_pc, exp_pc);
        chk("rnd.instr", id_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_hold   = imem_req && !imem_rvalid;
      prev_redir  = redirect_valid;
      prev_free   = !(imem_req && !imem_rvalid);
      prev_target = redirect_pc;
      prev_addr   = imem_addr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    chk("rnd.progress", pops >= 200, 1'b1);

`ifdef IFETCH_PERF_EN
    // 10 accepted fetches, 3 stall cycles, 1 redirect.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 16; c++) begin
      imem_rvalid = (c <= 10);
      id_ready = !((c >= 11) && (c <= 13));
      redirect_valid = (c == 15);
      redirect_pc = 16'h0200;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    $display("[perf] fetch=%0d stall=%0d flush=%0d", pf_fetch, pf_stall, pf_flush);
    chk("perf.fetch", pf_fetch, 32'd10);
    chk("perf.stall", pf_stall, 32'd3);
    chk("perf.flush", pf_flush, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch front end for the four-stage pipeline. Generates the fetch address stream, with sequential PC+1 increment and redirect on branch/jump. Runs a single-outstanding request/response handshake to instruction memory and buffers up to two fetched instructions. Delivers each instruction with its PC to decode over a valid/ready interface.

## Interface
- ASIZE, 16: instruction address width (word addressing).
- ISIZE, 32: instruction width.
- RESET_PC, 0: fetch address loaded on reset.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  fetch request; held until completed.
- imem_addr  out  ASIZE  fetch address; stable while imem_req high.
- imem_rvalid  in  1  response; transfer completes in any cycle with imem_req && imem_rvalid.
- imem_rdata  in  ISIZE  instruction data, valid with imem_rvalid.
- id_valid  out  1  buffered instruction available.
- id_instr  out  ISIZE  head instruction.
- id_pc  out  ASIZE  address of head instruction.
- id_ready  in  1  decode accepts head when id_valid && id_ready.
- redirect_valid  in  1  one-cycle pulse: flush and refetch.
- redirect_pc  in  ASIZE  new fetch address.

## Operation
- States: FETCH (normal), DISCARD (in-flight request whose response must be dropped).
- Reset: fetch_pc=RESET_PC, state FETCH, buffer empty, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Issue rule (FETCH): imem_req registered; asserted next cycle when post-update buffer occupancy <2 and no request is left pending. A pending request stays asserted with unchanged imem_addr until completion, regardless of id_ready.
- Completion in FETCH: push {imem_addr, imem_rdata} into buffer; fetch_pc <= imem_addr+1. Increment is modulo 2^ASIZE (all-ones wraps to 0).
- Pop: id_valid && id_ready removes head. Push and pop in the same cycle are both honoured; occupancy unchanged.
- Buffer never overflows: issue is gated on occupancy, and at most one request is outstanding.
- Redirect (highest priority): buffer flushed and fetch_pc <= redirect_pc; id_valid=0 next cycle. A pop in the redirect cycle is still a legal transfer.
  - If no request is pending, or the request completes in the redirect cycle: that response is dropped; state stays FETCH; the next request uses redirect_pc.
  - If a request is pending and not completing: go to DISCARD. imem_req/imem_addr are held; the completing response is dropped; next cycle return to FETCH and issue redirect_pc.
- Redirect while in DISCARD: update the target to the latest redirect_pc; stay in DISCARD.
- Reset mid-transfer: everything returns to reset values at once; the in-flight response is ignored by the protocol.

## Timing
- imem_req first high in the cycle after the first rising edge following rst deassertion.
- Completion at edge N: id_valid high after edge N (one-cycle latency); id_pc/id_instr registered.
- Zero-wait memory (imem_rvalid tied high) with id_ready high gives one instruction per cycle.
- id_ready low: buffer fills to 2; imem_req drops after the second completion.
- Redirect at edge N, no pending request: imem_req=1 with imem_addr=redirect_pc after edge N.

## Configuration
- IFETCH_PERF_EN defined adds three 32-bit saturating outputs, each reset to 0:
  - perf_fetch_cnt: accepted (non-dropped) completions.
  - perf_stall_cnt: cycles with id_valid && !id_ready.
  - perf_flush_cnt: redirect pulses.
- IFETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared define header holds ASIZE and ISIZE defaults; state encodings are localparams.
- Sub-module ifetch_buf: 2-entry FIFO of {pc, instr} with push, pop, flush, count, and head outputs.

## Test plan
- Reset release, imem_rvalid tied 1, id_ready 1 -> imem_addr 0,1,2,3 on consecutive cycles; id_pc 0,1,2 one cycle later.
- id_ready low for 5 cycles from PC 4 -> buffer holds PCs 4,5; imem_req low; on release id_pc 4 then 5, and fetch resumes at 6.
- imem_rvalid delayed 3 cycles on addr 2 -> imem_addr held at 2 for all cycles; instruction delivered once.
- Redirect to 0x0100 while request to 7 is pending -> DISCARD; response for 7 never appears on id_*; next request addr 0x0100.
- Redirect to 0x0040 coincident with completion of 9 -> 9 dropped; buffer empty next cycle; next imem_addr 0x0040. RESET_PC=0xFFFF -> second fetch address 0x0000.
- With IFETCH_PERF_EN: 10 fetches, 3 stall cycles, 1 redirect -> counters read 10, 3, 1.
